// File: rtl/top_k_result_streamer.sv
// Drains the ranked top-k result set as a serial 32-bit beat stream, holding the queue frozen meanwhile.
// Optional macro TOPK_STREAM_SKIP_EMPTY_EN skips entries whose similarity is zero.
module top_k_result_streamer #(
    parameter int K             = 5,
    parameter int EMBEDDING_DIM = 384
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    output logic                                      hold_queue,
    input  logic [K-1:0][31:0]                        topk_similarities,
    input  logic [K-1:0][31:0]                        topk_indices,
    input  logic [K-1:0][EMBEDDING_DIM-1:0][31:0]     topk_vectors,
    output logic                                      m_valid,
    input  logic                                      m_ready,
    output logic [31:0]                               m_data,
    output logic                                      m_sof,
    output logic                                      m_last,
    output logic [$clog2(K+1)-1:0]                    m_rank,
    output logic                                      done,
    output logic [$clog2(K+1)-1:0]                    entry_count
);
    localparam int RANK_W = $clog2(K+1);
    localparam int BEAT_W = $clog2(EMBEDDING_DIM+2);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(EMBEDDING_DIM+1);
    localparam logic [RANK_W-1:0] NO_RANK   = RANK_W'(K);

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t              state_q, state_d;
    logic [RANK_W-1:0]   rank_q, rank_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [RANK_W-1:0]   entry_count_q, entry_count_d;

    logic [K-1:0]        live;
    logic [RANK_W-1:0]   first_rank, next_rank, live_count;
    logic [31:0]         sel_index, sel_sim, sel_word;
    logic [EMBEDDING_DIM-1:0][31:0] sel_row;

    // An entry is "live" when it belongs in the stream.
    always_comb begin
        live = '0;
        for (int r = 0; r < K; r++) begin
`ifdef TOPK_STREAM_SKIP_EMPTY_EN
            live[r] = (topk_similarities[r] != 32'h0);
`else
            live[r] = 1'b1;
`endif
        end
    end

    // Scanning downward leaves the lowest qualifying rank in each result.
    always_comb begin
        first_rank = NO_RANK;
        next_rank  = NO_RANK;
        live_count = '0;
        for (int r = K-1; r >= 0; r--) begin
            if (live[r]) begin
                first_rank = RANK_W'(r);
                live_count = live_count + RANK_W'(1);
                if (RANK_W'(r) > rank_q) next_rank = RANK_W'(r);
            end
        end
    end

    always_comb begin
        sel_index = '0;
        sel_sim   = '0;
        sel_row   = '0;
        sel_word  = '0;
        for (int r = 0; r < K; r++) begin
            if (rank_q == RANK_W'(r)) begin
                sel_index = topk_indices[r];
                sel_sim   = topk_similarities[r];
                sel_row   = topk_vectors[r];
            end
        end
        for (int w = 0; w < EMBEDDING_DIM; w++) begin
            if (beat_q == BEAT_W'(w+2)) sel_word = sel_row[w];
        end
    end

    always_comb begin
        state_d       = state_q;
        rank_d        = rank_q;
        beat_d        = beat_q;
        entry_count_d = entry_count_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    rank_d = first_rank;
                    beat_d = '0;
                    if (first_rank == NO_RANK) begin
                        state_d       = DONE;
                        entry_count_d = live_count;
                    end else begin
                        state_d = SEND;
                    end
                end
            end
            SEND: begin
                if (m_ready) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d = '0;
                        rank_d = next_rank;
                        if (next_rank == NO_RANK) begin
                            state_d       = DONE;
                            entry_count_d = live_count;
                        end
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            rank_q        <= '0;
            beat_q        <= '0;
            entry_count_q <= '0;
        end else begin
            state_q       <= state_d;
            rank_q        <= rank_d;
            beat_q        <= beat_d;
            entry_count_q <= entry_count_d;
        end
    end

    // Beat outputs are pure decodes of registered counters, so they hold steady during stalls.
    always_comb begin
        m_data = '0;
        if (m_valid) begin
            case (beat_q)
                BEAT_W'(0): m_data = sel_index;
                BEAT_W'(1): m_data = sel_sim;
                default:    m_data = sel_word;
            endcase
        end
    end

    assign m_valid     = (state_q == SEND);
    assign hold_queue  = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign m_sof       = m_valid && (beat_q == '0);
    assign m_last      = m_valid && (beat_q == LAST_BEAT) && (next_rank == NO_RANK);
    assign m_rank      = m_valid ? rank_q : '0;
    assign entry_count = entry_count_q;

endmodule

// File: tb/tb_top_k_result_streamer.sv
// Directed bench for top_k_result_streamer at K=3, EMBEDDING_DIM=4 (6 beats per entry).
// Expectations follow TOPK_STREAM_SKIP_EMPTY_EN when it is defined for the build.
module tb_top_k_result_streamer;
    localparam int K   = 3;
    localparam int DIM = 4;
    localparam int RW  = $clog2(K+1);
    localparam int W   = 32 + RW + 2;

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          start;
    logic                          hold_queue;
    logic [K-1:0][31:0]            sims;
    logic [K-1:0][31:0]            idx;
    logic [K-1:0][DIM-1:0][31:0]   vecs;
    logic                          m_valid;
    logic                          m_ready;
    logic [31:0]                   m_data;
    logic                          m_sof;
    logic                          m_last;
    logic [RW-1:0]                 m_rank;
    logic                          done;
    logic [RW-1:0]                 entry_count;

    int checks = 0;
    int errors = 0;
    logic [W-1:0]  exp_q[$];
    logic [31:0]   got[64];

    top_k_result_streamer #(.K(K), .EMBEDDING_DIM(DIM)) dut (
        .clk(clk), .rst(rst), .start(start), .hold_queue(hold_queue),
        .topk_similarities(sims), .topk_indices(idx), .topk_vectors(vecs),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_sof(m_sof),
        .m_last(m_last), .m_rank(m_rank), .done(done), .entry_count(entry_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic set_data(input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] s2);
        sims[0] = s0; sims[1] = s1; sims[2] = s2;
        idx[0] = 32'd7; idx[1] = 32'd9; idx[2] = 32'd2;
        for (int r = 0; r < K; r++)
            for (int w = 0; w < DIM; w++)
                vecs[r][w] = 32'(16*r + w);
    endtask

    function automatic bit is_live(input int r);
`ifdef TOPK_STREAM_SKIP_EMPTY_EN
        return sims[r] != 32'h0;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic ready_at(input int mode, input int c);
        if (mode == 0) return 1'b1;
        return (c % 4 == 0) || (c % 4 == 3);
    endfunction

    task automatic build_expected();
        int last_r;
        logic [31:0] d;
        exp_q.delete();
        last_r = -1;
        for (int r = 0; r < K; r++) if (is_live(r)) last_r = r;
        for (int r = 0; r < K; r++) begin
            if (!is_live(r)) continue;
            for (int b = 0; b < DIM+2; b++) begin
                if (b == 0)      d = idx[r];
                else if (b == 1) d = sims[r];
                else             d = vecs[r][b-2];
                exp_q.push_back({(b == 0), (r == last_r && b == DIM+1), RW'(r), d});
            end
        end
    endtask

    task automatic run_xfer(input int mode, input bit mid_start, input int exp_beats,
                            input int exp_count, input int exp_done_cyc);
        int cyc = 0;
        int beats = 0;
        int done_cyc = -1;
        bit got_done = 0;
        bit stalled = 0;
        logic [W-1:0] prev;
        logic [W-1:0] obs;
        logic [W-1:0] e;
        build_expected();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        m_ready = ready_at(mode, 0);
        while (!got_done && cyc < 200) begin
            @(negedge clk);
            obs = {m_sof, m_last, m_rank, m_data};
            check("hold_in_xfer", 32'(hold_queue), 32'd1);
            if (done) begin
                got_done = 1;
                done_cyc = cyc;
                check("valid_in_done", 32'(m_valid), 32'd0);
                check("entry_count", 32'(entry_count), 32'(exp_count));
            end else begin
                check("valid_in_xfer", 32'(m_valid), 32'd1);
                if (stalled) check("stall_stable", 32'(obs != prev), 32'd0);
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        check("extra_beat", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", obs[31:0], e[31:0]);
                        check("beat_flags", 32'(obs[W-1:32]), 32'(e[W-1:32]));
                    end
                    if (beats < 64) got[beats] = m_data;
                    beats++;
                end
                stalled = m_valid && !m_ready;
                prev = obs;
            end
            @(posedge clk); #1;
            start = mid_start && (cyc == 3);
            cyc++;
            m_ready = ready_at(mode, cyc);
        end
        start = 1'b0;
        check("done_seen", 32'(got_done), 32'd1);
        check("beat_count", 32'(beats), 32'(exp_beats));
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        if (exp_done_cyc >= 0) check("done_cycle", 32'(done_cyc), 32'(exp_done_cyc));
        @(negedge clk);
        check("idle_done", 32'(done), 32'd0);
        check("idle_hold", 32'(hold_queue), 32'd0);
        check("idle_valid", 32'(m_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; m_ready = 1'b0;
        set_data(32'd30, 32'd20, 32'd10);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_hold", 32'(hold_queue), 32'd0);
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_sof", 32'(m_sof), 32'd0);
        check("rst_last", 32'(m_last), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rank", 32'(m_rank), 32'd0);
        check("rst_count", 32'(entry_count), 32'd0);
        check("rst_data", m_data, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Full-rate transfer; 18 beats then done on the 19th cycle after the start edge.
        run_xfer(0, 1'b0, 18, 3, 18);
        check("lit_b0", got[0], 32'd7);
        check("lit_b1", got[1], 32'd30);
        check("lit_b2", got[2], 32'd0);
        check("lit_b6", got[6], 32'd9);
        check("lit_b7", got[7], 32'd20);
        check("lit_b8", got[8], 32'd16);
        check("lit_b17", got[17], 32'd35);

        // Backpressure 1,0,0,1 and a start pulse mid-transfer.
        run_xfer(1, 1'b0, 18, 3, -1);
        run_xfer(0, 1'b1, 18, 3, 18);

        // Asynchronous reset after beat 8 abandons the transfer.
        @(posedge clk); #1 start = 1'b1; m_ready = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_valid", 32'(m_valid), 32'd0);
        check("abort_hold", 32'(hold_queue), 32'd0);
        check("abort_data", m_data, 32'd0);
        check("abort_count", 32'(entry_count), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_done", 32'(done), 32'd0);
        end
        @(posedge clk); #1 rst = 1'b0;
        run_xfer(0, 1'b0, 18, 3, 18);
        check("restart_b0", got[0], 32'd7);

        // Middle entry empty.
        set_data(32'd30, 32'd0, 32'd10);
`ifdef TOPK_STREAM_SKIP_EMPTY_EN
        run_xfer(0, 1'b0, 12, 2, 12);
        check("skip_b6_index", got[6], 32'd2);
        check("skip_b11_word", got[11], 32'd35);
`else
        run_xfer(0, 1'b0, 18, 3, 18);
        check("noskip_b7_sim", got[7], 32'd0);
`endif

        // All entries empty.
        set_data(32'd0, 32'd0, 32'd0);
`ifdef TOPK_STREAM_SKIP_EMPTY_EN
        run_xfer(0, 1'b0, 0, 0, 0);
`else
        run_xfer(1, 1'b0, 18, 3, -1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
